led_matrix_scan_ctrl: RTL

//  HUB75 row-scan / bit-plane sequencer for the LED panel; parametrised successor of the single-plane row scanner.

---
 rtl/led_matrix_scan_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/led_matrix_scan_ctrl.sv
// HUB75 row-scan / bit-plane sequencer.
// Walks ROWS rows x PWM_BITS binary-weighted bit-planes, drives row_addr,
// blank and latch, and prefetches the next line from the line shifter one
// line ahead so the BCM on-time of every plane is exact.
//
// Shifter handshake: next_line_begin is a 1-cycle pulse that starts a
// transfer of (next_line_addr, next_line_pwm); the transfer stays outstanding
// until next_line_done pulses for 1 cycle (a done in the same cycle as the
// begin counts). A done with no transfer outstanding is ignored. Completion is
// remembered in done_seen until the next begin is issued.
module led_matrix_scan_ctrl #(
    parameter int ROWS           = 24,
    parameter int ROW_W          = 5,
    parameter int PWM_BITS       = 7,
    parameter int BASE_ON_CYCLES = 16,
    parameter int LATCH_CYCLES   = 1,
    localparam int PL_W = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1
) (
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic             enable,
    output logic [ROW_W-1:0] row_addr,
    output logic             blank,
    output logic             latch,
    output logic             next_line_begin,
    input  logic             next_line_done,
    output logic [ROW_W-1:0] next_line_addr,
    output logic [PL_W-1:0]  next_line_pwm,
    output logic             frame_start,
    output logic [2:0]       scan_state,
    output logic [PL_W-1:0]  scan_plane
);

    // Timer must hold BASE_ON_CYCLES << (PWM_BITS-1) without overflow.
    localparam int TW  = $clog2(BASE_ON_CYCLES) + PWM_BITS;
    localparam int LCW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_LATCH = 3'd2,
        S_SWAP  = 3'd3,
        S_SHOW  = 3'd4
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [LCW-1:0]  lat_cnt;
    logic [PL_W-1:0] cur_plane;
    logic            busy;       // transfer outstanding: begin issued, no done yet
    logic            done_seen;  // prefetched line is ready in the shifter

    logic line_ready;
    assign line_ready = done_seen || (next_line_done && busy);

    assign scan_state = state;
    assign scan_plane = cur_plane;

    // Scan sequencer: all outputs registered, one line per WAIT/LATCH/SWAP/SHOW pass.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state           <= S_IDLE;
            row_addr        <= '0;
            blank           <= 1'b1;
            latch           <= 1'b0;
            next_line_begin <= 1'b0;
            next_line_addr  <= '0;
            next_line_pwm   <= '0;
            frame_start     <= 1'b0;
            cur_plane       <= '0;
            timer           <= '0;
            lat_cnt         <= '0;
            busy            <= 1'b0;
            done_seen       <= 1'b0;
        end else begin
            next_line_begin <= 1'b0;
            frame_start     <= 1'b0;
            if (next_line_done && busy) begin
                done_seen <= 1'b1;
                busy      <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    blank <= 1'b1;
                    latch <= 1'b0;
                    if (enable) begin
                        next_line_addr  <= '0;
                        next_line_pwm   <= '0;
                        next_line_begin <= 1'b1;
                        busy            <= 1'b1;
                        done_seen       <= 1'b0;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (line_ready) begin
                        if (enable) begin
                            latch   <= 1'b1;
                            lat_cnt <= LCW'(LATCH_CYCLES - 1);
                            state   <= S_LATCH;
                        end else begin
                            next_line_addr <= '0;
                            next_line_pwm  <= '0;
                            state          <= S_IDLE;
                        end
                    end
                end
                S_LATCH: begin
                    if (lat_cnt == '0) begin
                        latch <= 1'b0;
                        state <= S_SWAP;
                    end else begin
                        lat_cnt <= lat_cnt - LCW'(1);
                    end
                end
                S_SWAP: begin
                    latch       <= 1'b0;
                    row_addr    <= next_line_addr;
                    cur_plane   <= next_line_pwm;
                    frame_start <= (next_line_addr == '0) && (next_line_pwm == '0);
                    if (next_line_pwm == PL_W'(PWM_BITS - 1)) begin
                        next_line_pwm <= '0;
                        if (next_line_addr == ROW_W'(ROWS - 1))
                            next_line_addr <= '0;
                        else
                            next_line_addr <= next_line_addr + ROW_W'(1);
                    end else begin
                        next_line_pwm <= next_line_pwm + PL_W'(1);
                    end
                    next_line_begin <= 1'b1;
                    busy            <= 1'b1;
                    done_seen       <= 1'b0;
                    timer           <= TW'(BASE_ON_CYCLES) << next_line_pwm;
                    blank           <= 1'b0;
                    state           <= S_SHOW;
                end
                S_SHOW: begin
                    if (timer == TW'(1)) begin
                        timer <= '0;
                        blank <= 1'b1;
                        state <= S_WAIT;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
